// File: rtl/divider_arbiter_if.sv
// Bus between divider_arbiter and its requesters, result consumer and the shared divider.
// DIVARB_DIV0_EN adds the res_div0_out flag to the result channel.
interface divider_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 14
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // requester channels
  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic [NUM_REQ*WIDTH-1:0] req_dividend_in;
  logic [NUM_REQ*WIDTH-1:0] req_divisor_in;

  // shared divider
  logic [WIDTH-1:0]         div_dividend_out;
  logic [WIDTH-1:0]         div_divisor_out;
  logic                     div_valid_out;
  logic                     div_pause_out;
  logic [WIDTH-1:0]         div_quotient_in;
  logic                     div_valid_in;

  // result channel
  logic                     res_valid_out;
  logic                     res_ready_in;
  logic [ID_W-1:0]          res_id_out;
  logic [WIDTH-1:0]         res_quotient_out;
  logic                     err_out;
`ifdef DIVARB_DIV0_EN
  logic                     res_div0_out;
`endif

  // arbiter side
  modport slave (
    input  req_valid_in, req_dividend_in, req_divisor_in,
    output req_ready_out,
    output div_dividend_out, div_divisor_out, div_valid_out, div_pause_out,
    input  div_quotient_in, div_valid_in,
    output res_valid_out, res_id_out, res_quotient_out, err_out,
`ifdef DIVARB_DIV0_EN
    output res_div0_out,
`endif
    input  res_ready_in
  );

  // environment side: requesters, divider and result consumer
  modport master (
    output req_valid_in, req_dividend_in, req_divisor_in,
    input  req_ready_out,
    input  div_dividend_out, div_divisor_out, div_valid_out, div_pause_out,
    output div_quotient_in, div_valid_in,
    input  res_valid_out, res_id_out, res_quotient_out, err_out,
`ifdef DIVARB_DIV0_EN
    input  res_div0_out,
`endif
    output res_ready_in
  );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one LATENCY-stage pausable divider between NUM_REQ requesters.
// Optional DIVARB_DIV0_EN: tags divide-by-zero issues and flags/saturates their results.
module divider_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 14,
  parameter int LATENCY = 7
) (
  input logic              clk_in,
  input logic              rst_in,
  divider_arbiter_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {FLUSH, RUN} state_t;

  typedef struct packed {
    logic            valid;
`ifdef DIVARB_DIV0_EN
    logic            div0;
`endif
    logic [ID_W-1:0] id;
  } tag_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             in_run, stall, advance;

  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    gnt_id, cand;
  logic               gnt_found, grant_valid;
  logic [NUM_REQ-1:0] gnt_onehot;

  tag_t tag_in;
  tag_t tag_out;
  tag_t tag_q [LATENCY];

  logic             res_valid_q;
  logic [ID_W-1:0]  res_id_q;
  logic [WIDTH-1:0] res_quotient_q;
  logic             err_q;
`ifdef DIVARB_DIV0_EN
  logic             res_div0_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= FLUSH;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FLUSH:   if (flush_cnt_q == CNT_W'(LATENCY - 1)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = FLUSH;
    endcase
  end

  always_comb begin
    in_run = 1'b0;
    stall  = 1'b0;
    unique case (state_q)
      RUN: begin
        in_run = 1'b1;
        stall  = res_valid_q & ~bus.res_ready_in;
      end
      default: ;
    endcase
  end

  assign advance = in_run & ~stall;

  // The divider has no reset: LATENCY idle cycles push every stale valid bit out of it.
  always_ff @(posedge clk_in) begin
    if (rst_in)                 flush_cnt_q <= '0;
    else if (state_q == FLUSH)  flush_cnt_q <= flush_cnt_q + 1'b1;
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && bus.req_valid_in[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  assign grant_valid = advance & gnt_found;
  assign gnt_onehot  = grant_valid ? (NUM_REQ'(1) << gnt_id) : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in)           rr_ptr_q <= ID_W'(NUM_REQ - 1);
    else if (grant_valid) rr_ptr_q <= gnt_id;
  end

  assign bus.req_ready_out    = gnt_onehot;
  assign bus.div_valid_out    = grant_valid;
  assign bus.div_pause_out    = stall;
  assign bus.div_dividend_out = grant_valid ? bus.req_dividend_in[int'(gnt_id)*WIDTH +: WIDTH] : '0;
  assign bus.div_divisor_out  = grant_valid ? bus.req_divisor_in[int'(gnt_id)*WIDTH +: WIDTH]  : '0;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = grant_valid;
    tag_in.id    = gnt_id;
`ifdef DIVARB_DIV0_EN
    tag_in.div0  = grant_valid && (bus.div_divisor_out == '0);
`endif
  end

  // NOTE: the tag pipe is reset (unlike the divider datapath) because its valid bits decide what is reported.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else if (advance) begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[LATENCY-1];

  // Result register: the tag decides validity; a disagreeing divider valid only raises err.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      res_valid_q    <= 1'b0;
      res_id_q       <= '0;
      res_quotient_q <= '0;
      err_q          <= 1'b0;
`ifdef DIVARB_DIV0_EN
      res_div0_q     <= 1'b0;
`endif
    end else if (advance) begin
      res_valid_q <= tag_out.valid;
      res_id_q    <= tag_out.id;
`ifdef DIVARB_DIV0_EN
      res_div0_q     <= tag_out.valid & tag_out.div0;
      res_quotient_q <= (tag_out.valid & tag_out.div0) ? {WIDTH{1'b1}} : bus.div_quotient_in;
`else
      res_quotient_q <= bus.div_quotient_in;
`endif
      if (tag_out.valid != bus.div_valid_in) err_q <= 1'b1;
    end
  end

  assign bus.res_valid_out    = res_valid_q;
  assign bus.res_id_out       = res_id_q;
  assign bus.res_quotient_out = res_quotient_q;
  assign bus.err_out          = err_q;
`ifdef DIVARB_DIV0_EN
  assign bus.res_div0_out     = res_div0_q;
`endif
endmodule
